// File: rtl/div_repsub.sv
// Sequential unsigned divider by repeated subtraction. Dividend and divisor share
// one operand bus on consecutive cycles; a start/done handshake frames each divide.
module div_repsub #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    CHK  = 3'd3,
    SUB  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t       state_r;
  state_t       next_s;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] q_r;
  logic         done_r;
  logic         busy_r;
  logic         dbz_r;
  logic         ge_s;
  logic         b_zero_s;

  assign ge_s     = (a_r >= b_r);
  assign b_zero_s = (b_r == {W{1'b0}});

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Controller next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_s = LDA;
        else       next_s = IDLE;
      end
      LDA: next_s = LDB;
      LDB: next_s = CHK;
      CHK: begin
        if (b_zero_s) next_s = DONE;
        else          next_s = SUB;
      end
      SUB: begin
        if (ge_s) next_s = SUB;
        else      next_s = DONE;
      end
      DONE: begin
        if (start) next_s = LDA;
        else       next_s = DONE;
      end
      default: next_s = IDLE;
    endcase
  end

  // Datapath: operand capture, subtract and quotient count
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= {W{1'b0}};
      b_r <= {W{1'b0}};
      q_r <= {W{1'b0}};
    end else begin
      case (state_r)
        LDA: begin
          a_r <= data_in;
          q_r <= {W{1'b0}};
        end
        LDB: b_r <= data_in;
        SUB: begin
          if (ge_s) begin
            a_r <= a_r - b_r;
            q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          a_r <= a_r;
        end
      endcase
    end
  end

  // Status flags registered from the upcoming state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b0;
      busy_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= (next_s == DONE);
      busy_r <= (next_s == LDA) || (next_s == LDB) || (next_s == CHK) || (next_s == SUB);
      if (state_r == LDA) begin
        dbz_r <= 1'b0;
      end else if ((state_r == CHK) && b_zero_s) begin
        dbz_r <= 1'b1;
      end else begin
        dbz_r <= dbz_r;
      end
    end
  end

  assign quotient    = q_r;
  assign remainder   = a_r;
  assign done        = done_r;
  assign busy        = busy_r;
  assign div_by_zero = dbz_r;

endmodule
